icache_filler: RTL and testbench
================================

Name: icache_filler

Overview:
Fetch-side front end of the instruction cache. Looks up each fetch PC in the icache. On a hit it returns the instruction. On a miss it reads the word byte-by-byte from the memory controller, writes the assembled word into the icache through its fill port, and returns the instruction to the IF stage. It sits between IF, the icache and the memory arbiter.

Parameters:
ADDR_WIDTH, 32, width of PC and memory addresses
INST_WIDTH, 32, instruction width; always 4 bytes

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global ready; 0 freezes the block
flush  in  1  mispredict/redirect; aborts the current fetch
fetch_req  in  1  IF requests an instruction at fetch_pc
fetch_pc  in  32  fetch address
busy  out  1  high when state is not IDLE; IF must not raise fetch_req
inst_valid  out  1  one-cycle pulse, instruction returned
inst  out  32  returned instruction
inst_pc  out  32  word-aligned PC of the returned instruction
ic_addr  out  32  icache lookup address; combinational copy of fetch_pc
ic_hit  in  1  icache hit, combinational from ic_addr
ic_inst  in  32  icache data on hit
fill_en  out  1  one-cycle icache write strobe
fill_addr  out  32  icache write address
fill_data  out  32  icache write data
mem_rd  out  1  byte read request to the arbiter
mem_a  out  32  byte address
mem_gnt  in  1  arbiter grant; a read issues in a cycle where mem_rd and mem_gnt are both 1
mem_din  in  8  read data, valid exactly one cycle after issue

Behaviour:
- Reset (rst=0, async): state=IDLE, byte counter=0, pending=0, word=0. All registered outputs are 0: inst_valid, inst, inst_pc, fill_en, fill_addr, fill_data, mem_rd, mem_a.
- rdy=0: no state or register changes; mem_rd is forced 0; the pulse outputs hold their value. Consumers gate on rdy. The memory side holds mem_din while rdy=0.
- Priority under rdy=1: flush first, then the FSM.
- flush: next state IDLE, counter=0, pending=0. inst_valid and fill_en are 0 next cycle. A byte returning after the flush is ignored. A fetch_req in the same cycle as flush is dropped.
- Aligned base address = {fetch_pc[31:2],2'b00}; fetch_pc[1:0] is ignored.
- Little-endian assembly: byte k fills word bits [8k+7:8k].
- FSM states: IDLE, READ, LAST.
- IDLE, fetch_req=1, ic_hit=1:
  - next cycle: inst_valid=1, inst=ic_inst, inst_pc=base;
  - stays in IDLE, so hits sustain one per cycle.
- IDLE, fetch_req=1, ic_hit=0: latch base; go to READ with counter=0.
- IDLE, fetch_req=0: inst_valid and fill_en drop to 0.
- READ:
  - mem_rd=1, mem_a=base+counter.
  - On a grant, counter increments and pending=1 with index=counter.
  - Without a grant, mem_a holds.
  - Going to LAST happens after byte 3 issues.
- Each cycle with pending=1, mem_din is captured into byte[index]. pending clears unless another byte issued in that cycle.
- LAST:
  - mem_rd=0; capture byte 3.
  - Next cycle: inst_valid=1, fill_en=1, inst=fill_data=assembled word, inst_pc=fill_addr=base.
  - State goes to IDLE.
- Latency:
  - Hit: 1 cycle.
  - Miss with continuous grant: accept in cycle 0, reads issue in cycles 1-4, LAST in cycle 5, pulses in cycle 6.
  - Each cycle without a grant adds 1 cycle.
- fetch_req while busy is ignored.
- base+3 never wraps because base is aligned. Address arithmetic is mod 2^32.

Decomposition:
- Shared package holds the state enum (IDLE/READ/LAST), BYTES_PER_INST=4 and the byte counter width (2).
- No sub-module; byte assembly is a few lines inside the FSM.

Test Plan:
- Reset mid-miss: drop rst to 0 in cycle 3 of a fill. All outputs go to 0 immediately, busy=0. After release, a new fetch_req is accepted.
- Hit: pc=0x100, ic_hit=1, ic_inst=0x00000013. Next cycle inst_valid=1, inst=0x13, inst_pc=0x100; mem_rd and fill_en stay 0. Back-to-back hits at 0x100/0x104 give two consecutive pulses.
- Miss with gnt=1: pc=0x204, memory bytes 13,05,10,00. mem_a=0x204..0x207 in cycles 1-4. In cycle 6, inst_valid=fill_en=1 with inst=fill_data=0x00100513 and fill_addr=0x204.
- Grant stall plus misaligned PC: pc=0x207, gnt=0 in cycles 2-3. mem_a starts at 0x204 and holds 0x205 through the stall. Pulses arrive in cycle 8 with addr 0x204.
- Flush: assert flush in cycle 3 of a miss. No inst_valid or fill_en pulse; busy=0 next cycle. The late mem_din byte is ignored, and the next request fills correctly.
- rdy=0 for 3 cycles during READ: mem_rd=0, counter and mem_a frozen. The result is identical to the unstalled case, shifted by 3 cycles.

Source files
------------

// File: rtl/icache_filler_pkg.sv
// Shared types and constants for the instruction-cache fill front end.
package icache_filler_pkg;

  // Fetch FSM: idle/hit service, byte reads in flight, final byte capture.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAST = 2'd2
  } fill_state_e;

  localparam int BYTES_PER_INST = 4;
  localparam int CNT_W          = 2;
  localparam int INST_W         = 8 * BYTES_PER_INST;

  // Little-endian byte insert: byte idx lands in bits [8*idx+7 : 8*idx].
  function automatic logic [INST_W-1:0] put_byte(
    input logic [INST_W-1:0] word,
    input logic [CNT_W-1:0]  idx,
    input logic [7:0]        data
  );
    logic [INST_W-1:0] res;
    res = word;
    res[{idx, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/icache_filler.sv
// Instruction-cache front end: serves hits directly, fills misses byte by byte
// from the memory arbiter, writes the assembled word back and returns it to IF.
module icache_filler
  import icache_filler_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  busy,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic                  ic_hit,
  input  logic [INST_WIDTH-1:0] ic_inst,
  output logic                  fill_en,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [INST_WIDTH-1:0] fill_data,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_a,
  input  logic                  mem_gnt,
  input  logic [7:0]            mem_din
);

  fill_state_e             state_r,      state_s;
  logic [CNT_W-1:0]        cnt_r,        cnt_s;
  logic                    pend_r,       pend_s;
  logic [CNT_W-1:0]        pidx_r,       pidx_s;
  logic [INST_WIDTH-1:0]   word_r,       word_s;
  logic [ADDR_WIDTH-1:0]   base_r,       base_s;
  logic                    inst_valid_r, inst_valid_s;
  logic [INST_WIDTH-1:0]   inst_r,       inst_s;
  logic [ADDR_WIDTH-1:0]   inst_pc_r,    inst_pc_s;
  logic                    fill_en_r,    fill_en_s;
  logic [ADDR_WIDTH-1:0]   fill_addr_r,  fill_addr_s;
  logic [INST_WIDTH-1:0]   fill_data_r,  fill_data_s;
  logic                    mem_rd_r,     mem_rd_s;
  logic [ADDR_WIDTH-1:0]   mem_a_r,      mem_a_s;

  logic [ADDR_WIDTH-1:0]   aligned_pc_s;
  logic [INST_WIDTH-1:0]   word_cap_s;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic                    issue_s;

  assign ic_addr      = fetch_pc;
  assign aligned_pc_s = {fetch_pc[ADDR_WIDTH-1:2], 2'b00};
  assign cnt_inc_s    = cnt_r + 2'd1;
  // A byte read is issued only when the request is visible (rdy gates mem_rd).
  assign issue_s      = mem_rd && mem_gnt;

  assign busy       = (state_r != ST_IDLE);
  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign fill_en    = fill_en_r;
  assign fill_addr  = fill_addr_r;
  assign fill_data  = fill_data_r;
  assign mem_rd     = mem_rd_r && rdy;
  assign mem_a      = mem_a_r;

  // Merge the byte returning this cycle (if any) into the word being built.
  always_comb begin
    word_cap_s = word_r;
    if (pend_r) begin
      word_cap_s = put_byte(word_r, pidx_r, mem_din);
    end else begin
      word_cap_s = word_r;
    end
  end

  // Next-state and next-output logic; flush overrides all FSM activity.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    pend_s       = 1'b0;
    pidx_s       = pidx_r;
    word_s       = word_cap_s;
    base_s       = base_r;
    inst_valid_s = 1'b0;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    fill_en_s    = 1'b0;
    fill_addr_s  = fill_addr_r;
    fill_data_s  = fill_data_r;
    mem_rd_s     = mem_rd_r;
    mem_a_s      = mem_a_r;

    if (flush) begin
      // Abort: drop any in-flight byte and any same-cycle request.
      state_s  = ST_IDLE;
      cnt_s    = {CNT_W{1'b0}};
      word_s   = word_r;
      mem_rd_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mem_rd_s = 1'b0;
          if (fetch_req && ic_hit) begin
            inst_valid_s = 1'b1;
            inst_s       = ic_inst;
            inst_pc_s    = aligned_pc_s;
          end else if (fetch_req) begin
            base_s   = aligned_pc_s;
            cnt_s    = {CNT_W{1'b0}};
            state_s  = ST_READ;
            mem_rd_s = 1'b1;
            mem_a_s  = aligned_pc_s;
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_READ: begin
          if (issue_s) begin
            pend_s = 1'b1;
            pidx_s = cnt_r;
            cnt_s  = cnt_inc_s;
            if (cnt_r == 2'd3) begin
              // Last byte is out; its data is caught in LAST.
              state_s  = ST_LAST;
              mem_rd_s = 1'b0;
            end else begin
              mem_rd_s = 1'b1;
              mem_a_s  = base_r + {{(ADDR_WIDTH-CNT_W){1'b0}}, cnt_inc_s};
            end
          end else begin
            mem_rd_s = 1'b1;
          end
        end

        ST_LAST: begin
          // word_cap_s already holds byte 3, so the full word is ready now.
          state_s      = ST_IDLE;
          cnt_s        = {CNT_W{1'b0}};
          mem_rd_s     = 1'b0;
          inst_valid_s = 1'b1;
          fill_en_s    = 1'b1;
          inst_s       = word_cap_s;
          fill_data_s  = word_cap_s;
          inst_pc_s    = base_r;
          fill_addr_s  = base_r;
        end

        default: begin
          state_s  = ST_IDLE;
          cnt_s    = {CNT_W{1'b0}};
          mem_rd_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; rdy=0 freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      pend_r       <= 1'b0;
      pidx_r       <= {CNT_W{1'b0}};
      word_r       <= {INST_WIDTH{1'b0}};
      base_r       <= {ADDR_WIDTH{1'b0}};
      inst_valid_r <= 1'b0;
      inst_r       <= {INST_WIDTH{1'b0}};
      inst_pc_r    <= {ADDR_WIDTH{1'b0}};
      fill_en_r    <= 1'b0;
      fill_addr_r  <= {ADDR_WIDTH{1'b0}};
      fill_data_r  <= {INST_WIDTH{1'b0}};
      mem_rd_r     <= 1'b0;
      mem_a_r      <= {ADDR_WIDTH{1'b0}};
    end else if (rdy) begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pend_r       <= pend_s;
      pidx_r       <= pidx_s;
      word_r       <= word_s;
      base_r       <= base_s;
      inst_valid_r <= inst_valid_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      fill_en_r    <= fill_en_s;
      fill_addr_r  <= fill_addr_s;
      fill_data_r  <= fill_data_s;
      mem_rd_r     <= mem_rd_s;
      mem_a_r      <= mem_a_s;
    end
  end

endmodule

// File: tb/tb_icache_filler.sv
// Directed testbench for icache_filler with a byte-wide memory responder.
module tb_icache_filler;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        busy;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] ic_addr;
  logic        ic_hit;
  logic [31:0] ic_inst;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        mem_rd;
  logic [31:0] mem_a;
  logic        mem_gnt;
  logic [7:0]  mem_din;

  int n_tests;
  int n_fail;

  icache_filler dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .busy       (busy),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .ic_addr    (ic_addr),
    .ic_hit     (ic_hit),
    .ic_inst    (ic_inst),
    .fill_en    (fill_en),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .mem_rd     (mem_rd),
    .mem_a      (mem_a),
    .mem_gnt    (mem_gnt),
    .mem_din    (mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x204..0x207 hold 13 05 10 00, elsewhere addr[7:0]^5A.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'h204: b = 8'h13;
      32'h205: b = 8'h05;
      32'h206: b = 8'h10;
      32'h207: b = 8'h00;
      default: b = a[7:0] ^ 8'h5A;
    endcase
    return b;
  endfunction

  // Memory responder: data valid the cycle after an issued read, held otherwise.
  always @(posedge clk) begin
    if (mem_rd && mem_gnt) mem_din <= mem_byte(mem_a);
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Run a miss from request to one cycle past the pulse. a_tab nibble c gives the
  // expected mem_a offset from base in cycle c, or F when mem_rd must be low.
  task automatic miss_run(input logic [31:0] pc, input logic [31:0] base,
                          input logic [63:0] a_tab, input logic [15:0] gnt_off,
                          input logic [15:0] rdy_off, input int pulse,
                          input logic [31:0] word);
    logic [3:0] nib;
    cyc();
    fetch_req = 1'b1; fetch_pc = pc; ic_hit = 1'b0; mem_gnt = 1'b1; rdy = 1'b1;
    mid();
    chk_eq("miss_busy_c0", 32'(busy), 32'd0);
    for (int c = 1; c <= pulse + 1; c++) begin
      cyc();
      fetch_req = 1'b0;
      mem_gnt   = ~gnt_off[c];
      rdy       = ~rdy_off[c];
      mid();
      nib = a_tab[4*c +: 4];
      if (nib == 4'hF) begin
        chk_eq("miss_mem_rd_lo", 32'(mem_rd), 32'd0);
      end else begin
        chk_eq("miss_mem_rd_hi", 32'(mem_rd), 32'd1);
        chk_eq("miss_mem_a", mem_a, base + {28'd0, nib});
      end
      chk_eq("miss_inst_valid", 32'(inst_valid), 32'(c == pulse));
      chk_eq("miss_fill_en", 32'(fill_en), 32'(c == pulse));
      chk_eq("miss_busy", 32'(busy), 32'(c < pulse));
      if (c == pulse) begin
        chk_eq("miss_inst", inst, word);
        chk_eq("miss_fill_data", fill_data, word);
        chk_eq("miss_inst_pc", inst_pc, base);
        chk_eq("miss_fill_addr", fill_addr, base);
      end
    end
    rdy = 1'b1;
    mem_gnt = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; fetch_req = 1'b0; fetch_pc = 32'd0;
    ic_hit = 1'b0; ic_inst = 32'd0; mem_gnt = 1'b0; mem_din = 8'd0;

    // Reset state
    mid();
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk_eq("rst_mem_a", mem_a, 32'd0);
    chk_eq("rst_fill_en", 32'(fill_en), 32'd0);
    cyc();
    rst = 1'b1;

    // Back-to-back hits at 0x100 / 0x104
    cyc();
    fetch_req = 1'b1; fetch_pc = 32'h100; ic_hit = 1'b1; ic_inst = 32'h0000_0013;
    mid();
    chk_eq("hit_ic_addr", ic_addr, 32'h100);
    cyc();
    fetch_pc = 32'h104; ic_inst = 32'h00A0_0093;
    mid();
    chk_eq("hit1_valid", 32'(inst_valid), 32'd1);
    chk_eq("hit1_inst", inst, 32'h0000_0013);
    chk_eq("hit1_pc", inst_pc, 32'h100);
    chk_eq("hit1_mem_rd", 32'(mem_rd), 32'd0);
    chk_eq("hit1_fill_en", 32'(fill_en), 32'd0);
    chk_eq("hit1_busy", 32'(busy), 32'd0);
    cyc();
    fetch_req = 1'b0; ic_hit = 1'b0;
    mid();
    chk_eq("hit2_valid", 32'(inst_valid), 32'd1);
    chk_eq("hit2_inst", inst, 32'h00A0_0093);
    chk_eq("hit2_pc", inst_pc, 32'h104);
    cyc();
    mid();
    chk_eq("hit_idle_valid", 32'(inst_valid), 32'd0);

    // Miss with continuous grant
    miss_run(32'h204, 32'h204, 64'hFFFF_FFFF_FFF3_210F, 16'h0000, 16'h0000, 6, 32'h0010_0513);

    // Misaligned PC with grant stalled in cycles 2-3
    miss_run(32'h207, 32'h204, 64'hFFFF_FFFF_F321_110F, 16'h000C, 16'h0000, 8, 32'h0010_0513);

    // rdy low in cycles 2-4 during READ: same result three cycles later
    miss_run(32'h204, 32'h204, 64'hFFFF_FFFF_321F_FF0F, 16'h0000, 16'h001C, 9, 32'h0010_0513);

    // Flush in cycle 3 of a miss at 0x300, with a dropped same-cycle hit request
    cyc();
    fetch_req = 1'b1; fetch_pc = 32'h300; ic_hit = 1'b0; mem_gnt = 1'b1;
    cyc();
    fetch_req = 1'b0;
    cyc();
    cyc();
    flush = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h100; ic_hit = 1'b1; ic_inst = 32'hDEAD_BEEF;
    cyc();
    flush = 1'b0; fetch_req = 1'b0; ic_hit = 1'b0;
    mid();
    chk_eq("flush_busy", 32'(busy), 32'd0);
    chk_eq("flush_valid", 32'(inst_valid), 32'd0);
    chk_eq("flush_fill_en", 32'(fill_en), 32'd0);
    chk_eq("flush_mem_rd", 32'(mem_rd), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      mid();
      chk_eq("flush_no_pulse", 32'(inst_valid | fill_en), 32'd0);
    end
    // Refill 0x300: bytes 5A 5B 58 59
    miss_run(32'h300, 32'h300, 64'hFFFF_FFFF_FFF3_210F, 16'h0000, 16'h0000, 6, 32'h5958_5B5A);

    // Asynchronous reset in cycle 3 of a fill
    cyc();
    fetch_req = 1'b1; fetch_pc = 32'h204; ic_hit = 1'b0; mem_gnt = 1'b1;
    cyc();
    fetch_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk_eq("arst_busy", 32'(busy), 32'd0);
    chk_eq("arst_mem_rd", 32'(mem_rd), 32'd0);
    chk_eq("arst_mem_a", mem_a, 32'd0);
    chk_eq("arst_inst", inst, 32'd0);
    chk_eq("arst_inst_pc", inst_pc, 32'd0);
    chk_eq("arst_fill_addr", fill_addr, 32'd0);
    chk_eq("arst_fill_data", fill_data, 32'd0);
    chk_eq("arst_inst_valid", 32'(inst_valid | fill_en), 32'd0);
    cyc();
    rst = 1'b1;
    mid();
    chk_eq("arst_rel_busy", 32'(busy), 32'd0);
    miss_run(32'h204, 32'h204, 64'hFFFF_FFFF_FFF3_210F, 16'h0000, 16'h0000, 6, 32'h0010_0513);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
